control_fsm: RTL
================

# control_fsm

Multi-cycle main controller for the RV32I datapath. It decodes the latched instruction fields and steps a Moore state machine through fetch, decode, execute, memory and writeback. Each cycle it drives the datapath's mux selects, ALU control and write enables, and it consumes the ALU `zero` flag for branch resolution. It sits beside the datapath as the control end of the `AluSrc`/`ALUControl`/`MemWrite`/`ResultSrc`/`shift_right_type`/`zero` interface.

## Interface
- No parameters; all encodings come from `ctrl_pkg`.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `op` in 7: instruction [6:0], from the instruction register.
- `funct3` in 3: instruction [14:12].
- `funct7b5` in 1: instruction bit 30.
- `zero` in 1: ALU zero flag.
- `PCWrite` out 1: PC register enable.
- `AdrSrc` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `IRWrite` out 1: instruction and OldPC register enable.
- `MemWrite` out 1: data memory write enable.
- `RegWrite` out 1: register file write enable.
- `ResultSrc` out 2: result select. 00 = ALUOut, 01 = Data register, 10 = ALU result.
- `ALUSrcA` out 2: ALU source A. 00 = PC, 01 = OldPC, 10 = register A.
- `ALUSrcB` out 2: ALU source B. 00 = register B, 01 = ImmExt, 10 = constant 4.
- `ALUControl` out 3: ALU operation.
- `shift_right_type` out 1: 1 = arithmetic right shift.
- `ImmSrc` out 3: immediate format. 000 I, 001 S, 010 B, 011 J.
- `illegal_op` out 1: one-cycle pulse in DECODE for an unsupported opcode.
- `instr_done` out 1: one-cycle pulse in the final state of each instruction.

## Operation
- **ALUControl encodings:**
  - 000 ADD, 001 SUB, 010 AND, 011 OR
  - 100 XOR, 101 SLT, 110 SLL, 111 SR
- **Internal ALUOp, set per state:**
  - 00: ADD.
  - 01: SUB.
  - 10: decode from `funct3`:
    - 000: SUB only for R-type with `funct7b5`=1, else ADD.
    - 001 SLL, 010 and 011 SLT, 100 XOR, 110 OR, 111 AND.
    - 101: SR, with `shift_right_type`=`funct7b5`.
  - `shift_right_type`=0 in every other case.
- **States and outputs.** Any output not listed is 0.
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1. Next: DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ADD (branch and jump target into ALUOut). Next by `op`:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 1101111 → JAL
    - 1100011 → BRANCH
    - anything else → FETCH, with `illegal_op`=1
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ADD. Next: MEMREAD for a load, MEMWRITE for a store.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Next: MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1, instr_done=1. Next: FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, instr_done=1. Next: FETCH.
  - EXEC_R: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
  - EXEC_I: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1, instr_done=1. Next: FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=00, PCWrite=1. Next: ALUWB.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, SUB, ResultSrc=00, instr_done=1. Next: FETCH.
    - `funct3`=000: PCWrite=`zero`.
    - `funct3`=001: PCWrite=!`zero`.
    - Any other `funct3`: PCWrite=0.
- **Output logic.**
  - `ImmSrc` is decoded combinationally from `op` in every state: loads, I-ALU and unknown opcodes give 000.
  - All other outputs are functions of the state register, except:
    - ALUControl and `shift_right_type`, which also depend on `funct3`/`funct7b5`.
    - PCWrite in BRANCH, which also depends on `zero`.

## Timing
- Reset: state → FETCH asynchronously. While `rst`=1, PCWrite, IRWrite, RegWrite, MemWrite, `illegal_op` and `instr_done` are forced to 0.
  - First fetch happens on the first rising edge after `rst` deasserts.
- Cycles per instruction, FETCH to final state inclusive:
  - load 5
  - store, R-type, I-ALU, jal 4
  - branch 3
  - illegal 2
- Reset asserted mid-instruction: abandon immediately. No write enable may assert after `rst` rises.
- `op` and `funct*` are sampled only in DECODE and later states. They are stable from the IR after FETCH.

## Configuration
- `MEM_WAIT_EN` defined:
  - Adds input `mem_ready` (1 bit).
  - FETCH, MEMREAD and MEMWRITE hold their state while `mem_ready`=0.
  - In FETCH, IRWrite and PCWrite are gated by `mem_ready`.
  - In MEMWRITE, MemWrite stays asserted while waiting. `instr_done` fires only in the cycle where `mem_ready`=1.
- `MEM_WAIT_EN` undefined: no port; memory is treated as always ready, giving the latencies above.

## Structure
- `ctrl_pkg` holds:
  - the state enum
  - ALUControl, ResultSrc, ALUSrcA/B and ImmSrc localparams
  - opcode constants
- One sub-module, `alu_decoder`: a combinational map of ALUOp/`funct3`/`funct7b5`/`op`[5] → ALUControl and `shift_right_type`.
- The FSM and output decode live in `control_fsm`.

## Test plan
- **Reset:** `rst` pulsed mid-MEMWRITE → MemWrite drops in the same cycle. State is FETCH, and IRWrite=1 one cycle after release.
- **add x3,x1,x2** (op 0110011, funct3 000, f7b5 0) → 4 cycles. ALUControl=000 in EXEC_R; RegWrite=1 only in cycle 4.
- **Loads and stores:**
  - lw → 5 cycles, ResultSrc=01 with RegWrite in MEMWB.
  - sw → MemWrite=1 exactly in cycle 4, AdrSrc=1.
- **beq:**
  - with `zero`=1 → PCWrite=1 in cycle 3, ALUControl=001.
  - with `zero`=0 → PCWrite=0.
  - bne inverts both cases.
- **srai** (op 0010011, funct3 101, f7b5 1) → ALUControl=111, `shift_right_type`=1. sub via I-type with f7b5=1 → ADD.
- **Illegal op and memory wait:**
  - op 1111111 → `illegal_op` pulse in DECODE, back to FETCH in cycle 3.
  - With `MEM_WAIT_EN` and `mem_ready` low for 3 cycles in FETCH → IRWrite and PCWrite stay 0 and the state is held.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller: state enum, mux
// selects, ALU operations, opcodes and the immediate-format decode.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALUWB,
    S_JAL,
    S_BRANCH
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SR  = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALUOp/funct3/funct7b5/op[5] to ALUControl map, plus the
// arithmetic-vs-logical select for right shifts.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control,
  output logic       shift_right_type
);

  always_comb begin
    alu_control      = ALU_ADD;
    shift_right_type = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // funct7b5 means SUB only for R-type; in addi it is an immediate bit
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLT;
          3'b100:  alu_control = ALU_XOR;
          3'b101: begin
            alu_control      = ALU_SR;
            shift_right_type = funct7b5;
          end
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle Moore controller for the RV32I datapath.
// Define MEM_WAIT_EN to add the mem_ready handshake in FETCH/MEMREAD/MEMWRITE.
module control_fsm
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
`ifdef MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic       shift_right_type,
  output logic [2:0] ImmSrc,
  output logic       illegal_op,
  output logic       instr_done
);

  state_t     state_q, state_d;
  logic       mem_rdy;
  logic [1:0] alu_op;
  logic       pc_we, ir_we, mem_we, reg_we, illegal, done;

`ifdef MEM_WAIT_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    pc_we     = 1'b0;
    ir_we     = 1'b0;
    mem_we    = 1'b0;
    reg_we    = 1'b0;
    illegal   = 1'b0;
    done      = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_REGB;
    alu_op    = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        ir_we     = mem_rdy;
        pc_we     = mem_rdy;
        if (mem_rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch/jump target into ALUOut while decoding
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_ITYPE:          state_d = S_EXEC_I;
          OP_JAL:            state_d = S_JAL;
          OP_BRANCH:         state_d = S_BRANCH;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_REGA;
        ALUSrcB = SRCB_IMM;
        state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        reg_we    = 1'b1;
        done      = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_we = 1'b1;
        done   = mem_rdy;
        if (mem_rdy) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        ALUSrcA = SRCA_REGA;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXEC_I: begin
        ALUSrcA = SRCA_REGA;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_we  = 1'b1;
        done    = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        pc_we   = 1'b1;
        state_d = S_ALUWB;
      end
      S_BRANCH: begin
        ALUSrcA = SRCA_REGA;
        alu_op  = ALUOP_SUB;
        done    = 1'b1;
        case (funct3)
          3'b000:  pc_we = zero;
          3'b001:  pc_we = ~zero;
          default: pc_we = 1'b0;
        endcase
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op           (alu_op),
    .funct3           (funct3),
    .funct7b5         (funct7b5),
    .op5              (op[5]),
    .alu_control      (ALUControl),
    .shift_right_type (shift_right_type)
  );

  assign ImmSrc = imm_src_of(op);

  // Reset overrides every side effect so nothing writes while rst is high
  assign PCWrite    = pc_we   & ~rst;
  assign IRWrite    = ir_we   & ~rst;
  assign MemWrite   = mem_we  & ~rst;
  assign RegWrite   = reg_we  & ~rst;
  assign illegal_op = illegal & ~rst;
  assign instr_done = done    & ~rst;

endmodule
